// File: rtl/leaf_pkt_pkg.sv
// Shared packet layout, FSM state and width constants for the leaf output arbiter.
package leaf_pkt_pkg;

   localparam int unsigned PAYLOAD_BITS  = 32;
   localparam int unsigned NUM_LEAF_BITS = 5;
   localparam int unsigned NUM_PORT_BITS = 4;
   localparam int unsigned NUM_ADDR_BITS = 7;
   localparam int unsigned DST_BITS      = NUM_LEAF_BITS + NUM_PORT_BITS;
   localparam int unsigned PKT_BITS      = 1 + DST_BITS + NUM_ADDR_BITS + PAYLOAD_BITS;

   localparam int unsigned PKT_VLD_BIT   = 48;
   localparam int unsigned PKT_LEAF_MSB  = 47;
   localparam int unsigned PKT_LEAF_LSB  = 43;
   localparam int unsigned PKT_PORT_MSB  = 42;
   localparam int unsigned PKT_PORT_LSB  = 39;
   localparam int unsigned PKT_ADDR_MSB  = 38;
   localparam int unsigned PKT_ADDR_LSB  = 32;

   localparam int unsigned CREDIT_BITS   = 7;
   localparam int unsigned STAT_BITS     = 16;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } arb_state_e;

   typedef struct packed {
      logic                     vld;
      logic [NUM_LEAF_BITS-1:0] leaf;
      logic [NUM_PORT_BITS-1:0] port;
      logic [NUM_ADDR_BITS-1:0] addr;
      logic [PAYLOAD_BITS-1:0]  payload;
   } leaf_pkt_t;

   // Clamp a widened credit sum to the per-port ceiling.
   function automatic logic [CREDIT_BITS-1:0] sat_credit(
      input logic [CREDIT_BITS+1:0] sum,
      input logic [CREDIT_BITS-1:0] max_crd
   );
      if (sum > (CREDIT_BITS+2)'(max_crd)) return max_crd;
      return CREDIT_BITS'(sum);
   endfunction

endpackage

// File: rtl/leaf_out_arbiter_rr_picker.sv
// Rotating-priority one-hot selector: first requester strictly after last_i, wrapping.
module rr_picker #(
   parameter int unsigned N     = 3,
   parameter int unsigned IDX_W = 2
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] last_i,
   output logic [N-1:0]     gnt_c_o,
   output logic [IDX_W-1:0] idx_c_o
);

   int unsigned k;
   logic        found;

   always_comb begin
      gnt_c_o = '0;
      idx_c_o = last_i;
      found   = 1'b0;
      k       = 0;
      for (int unsigned off = 1; off <= N; off++) begin
         k = (32'(last_i) + off) % N;
         if (!found && req_i[IDX_W'(k)]) begin
            found               = 1'b1;
            gnt_c_o[IDX_W'(k)]  = 1'b1;
            idx_c_o             = IDX_W'(k);
         end
      end
   end

endmodule

// File: rtl/leaf_out_arbiter.sv
// Round-robin arbiter sharing the leaf->BFT packet link among user output streams,
// with per-port credits and sequence numbers. LEAF_OUT_ARB_STATS_EN adds stats_flat counters.
module leaf_out_arbiter
   import leaf_pkt_pkg::*;
#(
   parameter int unsigned NUM_OUT_PORTS = 3,
   parameter int unsigned MAX_CREDIT    = 64
) (
   input  logic                                  clk,
   input  logic                                  reset_n,
   input  logic                                  enable,
   input  logic                                  resend,
   input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_user,
   input  logic [NUM_OUT_PORTS-1:0]              vld_user,
   output logic [NUM_OUT_PORTS-1:0]              ack_user,
   input  logic                                  cfg_we,
   input  logic [2:0]                            cfg_port,
   input  logic [DST_BITS-1:0]                   cfg_dst,
   input  logic                                  cfg_clr,
   input  logic                                  crd_vld,
   input  logic [2:0]                            crd_port,
   input  logic [6:0]                            crd_amt,
   output logic [PKT_BITS-1:0]                   pkt_out,
   output logic                                  pkt_vld,
   input  logic                                  pkt_rdy
`ifdef LEAF_OUT_ARB_STATS_EN
   ,
   output logic [NUM_OUT_PORTS*32-1:0]           stats_flat
`endif
);

   localparam int unsigned IDX_W  = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
   localparam int unsigned CSUM_W = CREDIT_BITS + 2;
   localparam logic [CREDIT_BITS-1:0] CRD_MAX = CREDIT_BITS'(MAX_CREDIT);

   arb_state_e                 state_q, state_d;
   logic [IDX_W-1:0]           rr_q, rr_d;
   logic                       resend_pend_q, resend_pend_d;
   logic [CREDIT_BITS-1:0]     credit_q [NUM_OUT_PORTS];
   logic [CREDIT_BITS-1:0]     credit_d [NUM_OUT_PORTS];
   logic [NUM_ADDR_BITS-1:0]   seq_q    [NUM_OUT_PORTS];
   logic [NUM_ADDR_BITS-1:0]   seq_d    [NUM_OUT_PORTS];
   logic [DST_BITS-1:0]        dst_q    [NUM_OUT_PORTS];
   logic [NUM_OUT_PORTS-1:0]   ent_vld_q;
   logic [NUM_OUT_PORTS-1:0]   ack_q, ack_d;
   leaf_pkt_t                  pkt_q, pkt_d;
   logic                       pkt_vld_q, pkt_vld_d;

   logic [NUM_OUT_PORTS-1:0]   eligible, pick_oh, grant_oh;
   logic [IDX_W-1:0]           pick_idx;
   logic                       handshake, resend_apply, grant_en;

   always_comb begin
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
         eligible[i] = vld_user[i] & ent_vld_q[i] & (credit_q[i] != '0) & enable;
      end
   end

   rr_picker #(
      .N     (NUM_OUT_PORTS),
      .IDX_W (IDX_W)
   ) u_rr_picker (
      .req_i   (eligible),
      .last_i  (rr_q),
      .gnt_c_o (pick_oh),
      .idx_c_o (pick_idx)
   );

   // A resend seen mid-packet waits for the handshake; in IDLE it blocks that cycle's grant.
   assign handshake     = (state_q == SEND) & pkt_rdy;
   assign resend_apply  = ((state_q == IDLE) & resend) | (handshake & (resend | resend_pend_q));
   assign grant_en      = (state_q == IDLE) & (|eligible) & ~resend;
   assign grant_oh      = grant_en ? pick_oh : '0;
   assign resend_pend_d = handshake ? 1'b0 : (resend_pend_q | ((state_q == SEND) & resend));
   assign rr_d          = grant_en ? pick_idx : rr_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (grant_en) state_d = SEND;
         SEND:    if (pkt_rdy)  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ack_d     = grant_oh;
      pkt_vld_d = (state_d == SEND);
      pkt_d     = pkt_q;
      if (grant_en) begin
         pkt_d.vld                = 1'b1;
         {pkt_d.leaf, pkt_d.port} = dst_q[pick_idx];
         pkt_d.addr               = seq_q[pick_idx];
         pkt_d.payload            = din_user[int'(pick_idx)*PAYLOAD_BITS +: PAYLOAD_BITS];
      end
   end

   // Credit return and grant may land on the same port: add and subtract, then clamp.
   always_comb begin
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
         credit_d[i] = sat_credit(CSUM_W'(credit_q[i])
                                  + ((crd_vld && (int'(crd_port) == i)) ? CSUM_W'(crd_amt) : '0)
                                  - CSUM_W'(grant_oh[i]), CRD_MAX);
         seq_d[i]    = seq_q[i] + NUM_ADDR_BITS'(grant_oh[i]);
         if (resend_apply) begin
            credit_d[i] = CRD_MAX;
            seq_d[i]    = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rr_q          <= IDX_W'(NUM_OUT_PORTS - 1);
         resend_pend_q <= 1'b0;
         ack_q         <= '0;
         pkt_q         <= '0;
         pkt_vld_q     <= 1'b0;
         for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            credit_q[i] <= CRD_MAX;
            seq_q[i]    <= '0;
         end
      end else begin
         rr_q          <= rr_d;
         resend_pend_q <= resend_pend_d;
         ack_q         <= ack_d;
         pkt_q         <= pkt_d;
         pkt_vld_q     <= pkt_vld_d;
         for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            credit_q[i] <= credit_d[i];
            seq_q[i]    <= seq_d[i];
         end
      end
   end

   // Destination table; out-of-range indices match no entry.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ent_vld_q <= '0;
         for (int i = 0; i < NUM_OUT_PORTS; i++) dst_q[i] <= '0;
      end else if (cfg_we) begin
         for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            if (int'(cfg_port) == i) begin
               ent_vld_q[i] <= ~cfg_clr;
               if (!cfg_clr) dst_q[i] <= cfg_dst;
            end
         end
      end
   end

   assign ack_user = ack_q;
   assign pkt_out  = pkt_q;
   assign pkt_vld  = pkt_vld_q;

`ifdef LEAF_OUT_ARB_STATS_EN
   logic [STAT_BITS-1:0] grant_cnt_q [NUM_OUT_PORTS];
   logic [STAT_BITS-1:0] stall_cnt_q [NUM_OUT_PORTS];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            grant_cnt_q[i] <= '0;
            stall_cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            if (resend_apply) begin
               grant_cnt_q[i] <= '0;
               stall_cnt_q[i] <= '0;
            end else begin
               if (grant_oh[i] && (grant_cnt_q[i] != '1))
                  grant_cnt_q[i] <= grant_cnt_q[i] + STAT_BITS'(1);
               if (vld_user[i] && !ack_q[i] && ent_vld_q[i] && (stall_cnt_q[i] != '1))
                  stall_cnt_q[i] <= stall_cnt_q[i] + STAT_BITS'(1);
            end
         end
      end
   end

   always_comb begin
      stats_flat = '0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
         stats_flat[i*32 +: 32] = {stall_cnt_q[i], grant_cnt_q[i]};
      end
   end
`endif

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Directed bench for leaf_out_arbiter: vector table for arbitration order, hand sequences
// for backpressure, credit exhaustion/saturation, sequence wrap, resend and async reset.
module tb_leaf_out_arbiter;
   import leaf_pkt_pkg::*;

   localparam int unsigned N = 3;
   localparam logic [31:0] PAY0 = 32'hA5A5_0000;
   localparam logic [31:0] PAY1 = 32'h5A5A_1111;
   localparam logic [31:0] PAY2 = 32'hDEAD_2222;

   logic                  clk = 1'b0;
   logic                  reset_n, enable, resend;
   logic [N*32-1:0]       din_user;
   logic [N-1:0]          vld_user, ack_user;
   logic                  cfg_we, cfg_clr;
   logic [2:0]            cfg_port, crd_port;
   logic [DST_BITS-1:0]   cfg_dst;
   logic                  crd_vld;
   logic [6:0]            crd_amt;
   logic [PKT_BITS-1:0]   pkt_out;
   logic                  pkt_vld, pkt_rdy;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [N-1:0]        vld;
      logic                rdy;
      logic                en;
      logic [N-1:0]        exp_ack;
      logic                exp_vld;
      logic [PKT_BITS-1:0] exp_pkt;
   } vec_t;

   vec_t tbl [17];

   leaf_out_arbiter #(.NUM_OUT_PORTS(N), .MAX_CREDIT(64)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .enable   (enable),
      .resend   (resend),
      .din_user (din_user),
      .vld_user (vld_user),
      .ack_user (ack_user),
      .cfg_we   (cfg_we),
      .cfg_port (cfg_port),
      .cfg_dst  (cfg_dst),
      .cfg_clr  (cfg_clr),
      .crd_vld  (crd_vld),
      .crd_port (crd_port),
      .crd_amt  (crd_amt),
      .pkt_out  (pkt_out),
      .pkt_vld  (pkt_vld),
      .pkt_rdy  (pkt_rdy)
   );

   always #5 clk = ~clk;

   function automatic logic [PKT_BITS-1:0] mkpkt(input int unsigned leaf, input int unsigned port,
                                                 input int unsigned seq, input logic [31:0] pay);
      return {1'b1, 5'(leaf), 4'(port), 7'(seq), pay};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic idle(input int n);
      vld_user = '0;
      crd_vld  = 1'b0;
      resend   = 1'b0;
      cfg_we   = 1'b0;
      pkt_rdy  = 1'b1;
      repeat (n) step();
   endtask

   task automatic cfg_write(input int p, input logic [DST_BITS-1:0] d, input logic clr);
      cfg_we   = 1'b1;
      cfg_port = 3'(p);
      cfg_dst  = d;
      cfg_clr  = clr;
      step();
      cfg_we   = 1'b0;
      cfg_clr  = 1'b0;
   endtask

   task automatic count_acks(input int cycles, input int port, output int cnt, output logic [6:0] last_seq);
      cnt      = 0;
      last_seq = '0;
      for (int c = 0; c < cycles; c++) begin
         step();
         if (ack_user[port]) begin
            cnt++;
            last_seq = pkt_out[PKT_ADDR_MSB:PKT_ADDR_LSB];
         end
      end
   endtask

   task automatic wait_ack(input int port, input string nm);
      logic seen;
      seen = 1'b0;
      for (int c = 0; c < 6 && !seen; c++) begin
         step();
         seen = ack_user[port];
      end
      chk({nm, "_ack"}, 64'(seen), 64'd1);
   endtask

   initial begin
      int         cnt, c0, c1;
      logic [6:0] ls;

      reset_n  = 1'b0;  enable  = 1'b0; resend  = 1'b0;
      din_user = {PAY2, PAY1, PAY0};
      vld_user = '0;    cfg_we  = 1'b0; cfg_port = '0; cfg_dst = '0; cfg_clr = 1'b0;
      crd_vld  = 1'b0;  crd_port = '0;  crd_amt = '0;  pkt_rdy = 1'b1;

      tbl[0]  = '{3'b111, 1'b1, 1'b1, 3'b001, 1'b1, mkpkt(3, 1, 0, PAY0)};
      tbl[1]  = '{3'b111, 1'b1, 1'b1, 3'b000, 1'b0, '0};
      tbl[2]  = '{3'b111, 1'b1, 1'b1, 3'b010, 1'b1, mkpkt(4, 2, 0, PAY1)};
      tbl[3]  = '{3'b111, 1'b1, 1'b1, 3'b000, 1'b0, '0};
      tbl[4]  = '{3'b111, 1'b1, 1'b1, 3'b100, 1'b1, mkpkt(5, 0, 0, PAY2)};
      tbl[5]  = '{3'b111, 1'b1, 1'b1, 3'b000, 1'b0, '0};
      tbl[6]  = '{3'b111, 1'b1, 1'b1, 3'b001, 1'b1, mkpkt(3, 1, 1, PAY0)};
      tbl[7]  = '{3'b111, 1'b1, 1'b1, 3'b000, 1'b0, '0};
      tbl[8]  = '{3'b110, 1'b1, 1'b1, 3'b010, 1'b1, mkpkt(4, 2, 1, PAY1)};
      tbl[9]  = '{3'b110, 1'b1, 1'b1, 3'b000, 1'b0, '0};
      tbl[10] = '{3'b101, 1'b1, 1'b1, 3'b100, 1'b1, mkpkt(5, 0, 1, PAY2)};
      tbl[11] = '{3'b101, 1'b1, 1'b1, 3'b000, 1'b0, '0};
      tbl[12] = '{3'b111, 1'b1, 1'b0, 3'b000, 1'b0, '0};
      tbl[13] = '{3'b111, 1'b1, 1'b0, 3'b000, 1'b0, '0};
      tbl[14] = '{3'b011, 1'b1, 1'b1, 3'b001, 1'b1, mkpkt(3, 1, 2, PAY0)};
      tbl[15] = '{3'b011, 1'b0, 1'b1, 3'b000, 1'b1, mkpkt(3, 1, 2, PAY0)};
      tbl[16] = '{3'b011, 1'b1, 1'b1, 3'b000, 1'b0, '0};

      repeat (3) step();
      chk("rst_ack", 64'(ack_user), 64'd0);
      chk("rst_vld", 64'(pkt_vld), 64'd0);
      chk("rst_pkt", 64'(pkt_out), 64'd0);
      reset_n = 1'b1;
      step();

      cfg_write(0, {5'd3, 4'd1}, 1'b0);
      cfg_write(1, {5'd4, 4'd2}, 1'b0);
      cfg_write(2, {5'd5, 4'd0}, 1'b0);

      // Arbitration order, enable gating and a one-cycle stall.
      for (int i = 0; i < 17; i++) begin
         vld_user = tbl[i].vld;
         pkt_rdy  = tbl[i].rdy;
         enable   = tbl[i].en;
         step();
         chk($sformatf("vec%0d_ack", i), 64'(ack_user), 64'(tbl[i].exp_ack));
         chk($sformatf("vec%0d_vld", i), 64'(pkt_vld), 64'(tbl[i].exp_vld));
         if (tbl[i].exp_vld) chk($sformatf("vec%0d_pkt", i), 64'(pkt_out), 64'(tbl[i].exp_pkt));
      end

      // Backpressure: packet held stable for 10 cycles.
      vld_user = 3'b010; pkt_rdy = 1'b0;
      step();
      chk("t4_grant_ack", 64'(ack_user), 64'(3'b010));
      chk("t4_grant_pkt", 64'(pkt_out), 64'(mkpkt(4, 2, 2, PAY1)));
      for (int c = 0; c < 10; c++) begin
         step();
         chk("t4_hold_vld", 64'(pkt_vld), 64'd1);
         chk("t4_hold_pkt", 64'(pkt_out), 64'(mkpkt(4, 2, 2, PAY1)));
         chk("t4_hold_ack", 64'(ack_user), 64'd0);
      end
      pkt_rdy = 1'b1;
      step();
      chk("t4_release_vld", 64'(pkt_vld), 64'd0);
      step();
      chk("t4_resume_ack", 64'(ack_user), 64'(3'b010));
      chk("t4_resume_pkt", 64'(pkt_out), 64'(mkpkt(4, 2, 3, PAY1)));
      idle(2);

      // Resend in IDLE, then drain port 1 credits and refill by 5.
      resend = 1'b1; step(); resend = 1'b0;
      vld_user = 3'b010;
      count_acks(140, 1, cnt, ls);
      chk("t2_acks", 64'(cnt), 64'd64);
      chk("t2_last_seq", 64'(ls), 64'd63);
      crd_vld = 1'b1; crd_port = 3'd1; crd_amt = 7'd5;
      step();
      crd_vld = 1'b0;
      count_acks(30, 1, cnt, ls);
      chk("t2_refill_acks", 64'(cnt), 64'd5);
      vld_user = 3'b011; c0 = 0; c1 = 0;
      for (int c = 0; c < 8; c++) begin
         step();
         c0 += int'(ack_user[0]);
         c1 += int'(ack_user[1]);
      end
      chk("t2_other_port_acks", 64'(c0), 64'd4);
      chk("t2_starved_port_acks", 64'(c1), 64'd0);
      idle(2);

      // Invalidated table entry blocks its port.
      cfg_write(0, '0, 1'b1);
      vld_user = 3'b001;
      count_acks(6, 0, cnt, ls);
      chk("cfg_clr_acks", 64'(cnt), 64'd0);
      idle(1);
      cfg_write(0, {5'd3, 4'd1}, 1'b0);

      // Same-cycle grant and credit return on a full port stays saturated.
      vld_user = 3'b100; crd_vld = 1'b1; crd_port = 3'd2; crd_amt = 7'd3;
      step();
      crd_vld = 1'b0;
      chk("t3_first_ack", 64'(ack_user), 64'(3'b100));
      count_acks(150, 2, cnt, ls);
      chk("t3_more_acks", 64'(cnt), 64'd64);
      crd_vld = 1'b1; crd_port = 3'd3; crd_amt = 7'd5;
      step();
      crd_vld = 1'b0;
      count_acks(10, 2, cnt, ls);
      chk("crd_oob_acks", 64'(cnt), 64'd0);
      idle(2);

      // Sequence wrap over 130 packets with continuous credit return.
      resend = 1'b1; step(); resend = 1'b0;
      vld_user = 3'b001; crd_vld = 1'b1; crd_port = 3'd0; crd_amt = 7'd1;
      for (int k = 0; k < 130; k++) begin
         wait_ack(0, "t5");
         if (k == 127) chk("t5_seq127", 64'(pkt_out[PKT_ADDR_MSB:PKT_ADDR_LSB]), 64'd127);
         if (k == 128) chk("t5_seq_wrap", 64'(pkt_out[PKT_ADDR_MSB:PKT_ADDR_LSB]), 64'd0);
         if (k == 129) chk("t5_seq_after", 64'(pkt_out[PKT_ADDR_MSB:PKT_ADDR_LSB]), 64'd1);
      end
      idle(2);

      // Resend during SEND is deferred to the handshake.
      vld_user = 3'b001; pkt_rdy = 1'b0;
      wait_ack(0, "t6_pre");
      chk("t6_pre_seq", 64'(pkt_out[PKT_ADDR_MSB:PKT_ADDR_LSB]), 64'd2);
      vld_user = 3'b000; resend = 1'b1;
      step();
      resend = 1'b0;
      chk("t6_pend_vld", 64'(pkt_vld), 64'd1);
      chk("t6_pend_pkt", 64'(pkt_out), 64'(mkpkt(3, 1, 2, PAY0)));
      step();
      chk("t6_pend_vld2", 64'(pkt_vld), 64'd1);
      pkt_rdy = 1'b1;
      step();
      chk("t6_hs_vld", 64'(pkt_vld), 64'd0);
      vld_user = 3'b001;
      wait_ack(0, "t6_post");
      chk("t6_post_seq", 64'(pkt_out[PKT_ADDR_MSB:PKT_ADDR_LSB]), 64'd0);
      count_acks(140, 0, cnt, ls);
      chk("t6_remaining_credit", 64'(cnt), 64'd63);
      idle(2);

      // Async reset in SEND drops the packet without a clock edge.
      crd_vld = 1'b1; crd_port = 3'd0; crd_amt = 7'd2;
      step();
      crd_vld = 1'b0;
      vld_user = 3'b001; pkt_rdy = 1'b0;
      wait_ack(0, "arst");
      chk("arst_pre_vld", 64'(pkt_vld), 64'd1);
      #3;
      reset_n = 1'b0;
      #1;
      chk("arst_vld", 64'(pkt_vld), 64'd0);
      chk("arst_ack", 64'(ack_user), 64'd0);
      chk("arst_pkt", 64'(pkt_out), 64'd0);
      step();
      reset_n = 1'b1;
      idle(1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
